syn_m_sched: RTL and testbench
==============================

// Module: syn_m_sched
// PURPOSE
//  GPS-disciplined second scheduler for the master sync path. Qualifies the GPS
//  PPS, tracks lock and holdover, and issues the one-cycle fire_sync and fire_info
//  strobes that drive the sync-frame and info-frame transmitters. Replaces raw
//  PPS triggering, adding window check, missed-pulse holdover and error reporting.
// PARAMETERS
//  PERIOD_US    1000000  nominal second length in pluse_us ticks
//  WIN_US       50       +/- acceptance window around expected PPS, us
//  INFO_DLY_US  100      fire_info delay after fire_sync, us (WIN_US < INFO_DLY_US < PERIOD_US-WIN_US)
//  HOLD_MAX     8        consecutive holdover seconds before dropping to IDLE
// PORTS
//  clk_sys    in   1   system clock
//  rst_n      in   1   synchronous reset, active-low
//  pluse_us   in   1   1-cycle strobe, once per microsecond
//  gps_pluse  in   1   GPS PPS, asynchronous level
//  fire_sync  out  1   1-cycle strobe: start sync frame
//  fire_info  out  1   1-cycle strobe: start info frame
//  locked     out  1   1 in LOCK state
//  holdover   out  1   1 in HOLD state
//  err        out  1   timing error flag (level)
//  us_cnt     out  20  microsecond position within current second
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state IDLE; us_cnt, miss_cnt, dly_cnt, all outputs 0.
//  - gps_pluse: 2-FF sync + rising-edge detect -> gps_rise, 1 cycle, 3 clk after input edge.
//  - IDLE: us_cnt held 0, no strobes. gps_rise -> LOCK, us_cnt<=0, fire_sync next cycle, err<=0.
//  - LOCK: us_cnt +1 per pluse_us, no wrap. in-window = us_cnt in [PERIOD_US-WIN_US, PERIOD_US+WIN_US-1].
//    gps_rise in-window -> us_cnt<=0, fire_sync, err<=0.
//    gps_rise outside window -> ignored (no fire, no realign), err<=1.
//    pluse_us taking us_cnt to PERIOD_US+WIN_US (PPS missed) -> HOLD, us_cnt<=WIN_US,
//    fire_sync (late by WIN_US this second only; nominal phase kept), miss_cnt<=1.
//  - HOLD: free-run; pluse_us at us_cnt==PERIOD_US-1 -> us_cnt<=0, fire_sync, miss_cnt+1.
//    miss_cnt reaching HOLD_MAX at that wrap -> IDLE instead (no fire_sync), err<=1, miss_cnt<=0.
//    gps_rise with us_cnt<WIN_US -> LOCK, us_cnt<=0, no fire_sync (second already fired).
//    gps_rise otherwise -> LOCK, us_cnt<=0, fire_sync. Either case miss_cnt<=0.
//  - Simultaneous gps_rise and pluse_us: gps_rise wins; tick absorbed (us_cnt<=0).
//  - fire_info: dly_cnt cleared on every fire_sync, +1 per pluse_us while armed; fire_info
//    1 cycle when dly_cnt reaches INFO_DLY_US, then disarm. New fire_sync re-arms/cancels pending.
//    Entering IDLE disarms.
//  - fire_sync, fire_info registered: 1 cycle wide, never in same cycle.
//  - err: set as above, cleared only by accepted (in-window or IDLE-start) gps_rise or reset.
//  - locked/holdover decoded from registered state; us_cnt is the registered counter.
//  - Width: 20-bit counters; PERIOD_US+WIN_US must be < 2^20.
// TESTING (PERIOD_US=1000, WIN_US=10, INFO_DLY_US=20, HOLD_MAX=3, pluse_us every 4 clk)
//  1 Reset then first PPS -> fire_sync 4 clk after PPS edge, locked=1, fire_info 20 us later.
//  2 PPS every 1000 us, jitter +/-5 us -> one fire_sync per PPS, us_cnt reset, err=0.
//  3 PPS at us_cnt=500 while LOCK -> no fire_sync, err=1; next PPS at 1000 -> fire, err=0.
//  4 PPS stopped -> fire_sync at us_cnt 1010, holdover=1, then each 1000 us; after 3rd miss
//    -> IDLE, locked=holdover=0, err=1, no strobes.
//  5 PPS returns in HOLD at us_cnt=5 -> LOCK, no extra fire_sync; at us_cnt=600 -> fire_sync.
//  6 rst_n low for 1 clk mid-HOLD, during pending fire_info -> all outputs 0, no fire_info, IDLE.

Source files
------------

// File: rtl/syn_m_sched.sv
// GPS-disciplined second scheduler for the master sync path.
// Qualifies the GPS PPS against an expected window, tracks lock and holdover,
// and issues the fire_sync / fire_info strobes for the frame transmitters.
// Ports:
//   clk_sys    in   system clock
//   rst_n      in   synchronous reset, active-low
//   pluse_us   in   1-cycle strobe once per microsecond
//   gps_pluse  in   GPS PPS, asynchronous level
//   fire_sync  out  1-cycle strobe: start sync frame
//   fire_info  out  1-cycle strobe: start info frame, INFO_DLY_US after fire_sync
//   locked     out  1 while locked to PPS
//   holdover   out  1 while free-running after a missed PPS
//   err        out  timing error flag (level)
//   us_cnt     out  microsecond position within the current second
module syn_m_sched #(
    parameter int unsigned PERIOD_US   = 1000000,
    parameter int unsigned WIN_US      = 50,
    parameter int unsigned INFO_DLY_US = 100,
    parameter int unsigned HOLD_MAX    = 8
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic        gps_pluse,
    output logic        fire_sync,
    output logic        fire_info,
    output logic        locked,
    output logic        holdover,
    output logic        err,
    output logic [19:0] us_cnt
);
    localparam int unsigned CW = 20;
    localparam int unsigned MW = $clog2(HOLD_MAX + 1);

    localparam logic [CW-1:0] WIN_LO  = CW'(PERIOD_US - WIN_US);
    localparam logic [CW-1:0] WIN_HI  = CW'(PERIOD_US + WIN_US - 1);
    localparam logic [CW-1:0] WRAP_AT = CW'(PERIOD_US - 1);
    localparam logic [CW-1:0] WIN_C   = CW'(WIN_US);
    localparam logic [CW-1:0] DLY_C   = CW'(INFO_DLY_US);
    localparam logic [MW-1:0] HOLD_C  = MW'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_us_cnt, w_us_nxt;
    logic [CW-1:0]   r_dly_cnt, w_dly_nxt;
    logic [MW-1:0]   r_miss_cnt, w_miss_nxt;
    logic            r_armed, w_armed_nxt;
    logic            r_err, w_err_nxt;
    logic            r_fire_sync, w_fs_nxt;
    logic            r_fire_info, w_fi_nxt;
    logic            r_locked, r_holdover;
    logic            r_gps_meta, r_gps_sync, r_gps_dly, r_gps_rise;
    logic            w_in_win;

    // PPS synchronizer and registered rising-edge detect (rise 3 clk after input edge)
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_gps_meta <= 1'b0;
            r_gps_sync <= 1'b0;
            r_gps_dly  <= 1'b0;
            r_gps_rise <= 1'b0;
        end else begin
            r_gps_meta <= gps_pluse;
            r_gps_sync <= r_gps_meta;
            r_gps_dly  <= r_gps_sync;
            r_gps_rise <= r_gps_sync & ~r_gps_dly;
        end
    end

    assign w_in_win = (r_us_cnt >= WIN_LO) && (r_us_cnt <= WIN_HI);

    // Next-state, counter and strobe decisions
    always_comb begin
        w_state_nxt = r_state;
        w_us_nxt    = r_us_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_nxt   = r_err;
        w_dly_nxt   = r_dly_cnt;
        w_armed_nxt = r_armed;
        w_fs_nxt    = 1'b0;
        w_fi_nxt    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_us_nxt = '0;
                if (r_gps_rise) begin
                    w_state_nxt = ST_LOCK;
                    w_fs_nxt    = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_LOCK: begin
                // A rise coinciding with a tick realigns; the tick is absorbed.
                if (r_gps_rise && w_in_win) begin
                    w_us_nxt  = '0;
                    w_fs_nxt  = 1'b1;
                    w_err_nxt = 1'b0;
                end else begin
                    if (r_gps_rise) begin
                        w_err_nxt = 1'b1;
                    end
                    if (pluse_us) begin
                        if (r_us_cnt == WIN_HI) begin
                            // PPS missed: fire late, but keep the nominal phase.
                            w_state_nxt = ST_HOLD;
                            w_us_nxt    = WIN_C;
                            w_fs_nxt    = 1'b1;
                            w_miss_nxt  = MW'(1);
                        end else begin
                            w_us_nxt = r_us_cnt + CW'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (r_gps_rise) begin
                    // Early in the second the sync frame already went out.
                    w_state_nxt = ST_LOCK;
                    w_us_nxt    = '0;
                    w_miss_nxt  = '0;
                    w_fs_nxt    = (r_us_cnt >= WIN_C);
                end else if (pluse_us) begin
                    if (r_us_cnt == WRAP_AT) begin
                        w_us_nxt = '0;
                        if (r_miss_cnt + MW'(1) == HOLD_C) begin
                            w_state_nxt = ST_IDLE;
                            w_err_nxt   = 1'b1;
                            w_miss_nxt  = '0;
                        end else begin
                            w_fs_nxt   = 1'b1;
                            w_miss_nxt = r_miss_cnt + MW'(1);
                        end
                    end else begin
                        w_us_nxt = r_us_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_us_nxt    = '0;
            end
        endcase

        // Info-frame delay: every fire_sync restarts it, IDLE cancels it.
        if (w_fs_nxt) begin
            w_armed_nxt = 1'b1;
            w_dly_nxt   = '0;
        end else if (w_state_nxt == ST_IDLE) begin
            w_armed_nxt = 1'b0;
        end else if (r_armed && pluse_us) begin
            w_dly_nxt = r_dly_cnt + CW'(1);
            if (w_dly_nxt == DLY_C) begin
                w_fi_nxt    = 1'b1;
                w_armed_nxt = 1'b0;
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_us_cnt    <= '0;
            r_dly_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_armed     <= 1'b0;
            r_err       <= 1'b0;
            r_fire_sync <= 1'b0;
            r_fire_info <= 1'b0;
            r_locked    <= 1'b0;
            r_holdover  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_us_cnt    <= w_us_nxt;
            r_dly_cnt   <= w_dly_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_armed     <= w_armed_nxt;
            r_err       <= w_err_nxt;
            r_fire_sync <= w_fs_nxt;
            r_fire_info <= w_fi_nxt;
            r_locked    <= (w_state_nxt == ST_LOCK);
            r_holdover  <= (w_state_nxt == ST_HOLD);
        end
    end

    assign fire_sync = r_fire_sync;
    assign fire_info = r_fire_info;
    assign locked    = r_locked;
    assign holdover  = r_holdover;
    assign err       = r_err;
    assign us_cnt    = r_us_cnt;

endmodule

// File: tb/tb_syn_m_sched.sv
// Scoreboard bench for syn_m_sched with a microsecond-level reference model.
module tb_syn_m_sched;
    localparam int P = 1000;
    localparam int W = 10;
    localparam int D = 20;
    localparam int H = 3;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        pluse_us;
    logic        gps_pluse;
    logic        fire_sync, fire_info, locked, holdover, err;
    logic [19:0] us_cnt;

    syn_m_sched #(.PERIOD_US(P), .WIN_US(W), .INFO_DLY_US(D), .HOLD_MAX(H)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .gps_pluse(gps_pluse),
        .fire_sync(fire_sync), .fire_info(fire_info), .locked(locked),
        .holdover(holdover), .err(err), .us_cnt(us_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int kind;   // 1 = fire_sync, 2 = fire_info
        int at;     // clock edge at which the strobe appears
        int us;
        bit lk;
        bit ho;
        bit er;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // Reference model state: mode 0 idle, 1 locked, 2 holdover
    int   m_mode = 0, m_pos = 0, m_miss = 0, m_ticks = 0, m_info_due = -1;
    bit   m_err = 0, m_prev_g = 0;
    int   m_rises[$];

    task automatic push_exp(input int kind);
        exp_t e;
        e.kind = kind; e.at = edge_n; e.us = m_pos;
        e.lk = (m_mode == 1); e.ho = (m_mode == 2); e.er = m_err;
        exp_q.push_back(e);
    endtask

    // Applies the scheduler rules at one clock edge using what the DUT sampled.
    task automatic model_step();
        bit tick, rise, fs, fi;
        fs = 0; fi = 0; rise = 0;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_miss = 0; m_err = 0;
            m_info_due = -1; m_prev_g = 0; m_rises.delete();
            return;
        end
        tick = pluse_us;
        if (m_rises.size() > 0 && m_rises[0] == edge_n) begin
            rise = 1;
            void'(m_rises.pop_front());
        end
        if (gps_pluse && !m_prev_g) m_rises.push_back(edge_n + 3);
        m_prev_g = gps_pluse;
        if (tick) m_ticks++;
        case (m_mode)
            0: if (rise) begin m_mode = 1; m_pos = 0; fs = 1; m_err = 0; end
            1: begin
                if (rise && m_pos >= P - W && m_pos <= P + W - 1) begin
                    m_pos = 0; fs = 1; m_err = 0;
                end else begin
                    if (rise) m_err = 1;
                    if (tick) begin
                        m_pos++;
                        if (m_pos == P + W) begin m_mode = 2; m_pos = W; fs = 1; m_miss = 1; end
                    end
                end
            end
            default: begin
                if (rise) begin
                    fs = (m_pos >= W); m_mode = 1; m_pos = 0; m_miss = 0;
                end else if (tick) begin
                    m_pos++;
                    if (m_pos == P) begin
                        m_pos = 0; m_miss++;
                        if (m_miss == H) begin m_mode = 0; m_err = 1; m_miss = 0; end
                        else fs = 1;
                    end
                end
            end
        endcase
        if (fs) m_info_due = m_ticks + D;
        else if (m_mode == 0) m_info_due = -1;
        else if (tick && m_ticks == m_info_due) begin fi = 1; m_info_due = -1; end
        if (fs) push_exp(1);
        if (fi) push_exp(2);
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            edge_n++;
            model_step();
        end
    end

    // Microsecond tick every 4 clocks
    initial begin
        pluse_us = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            pluse_us = ((edge_n + 1) % 4 == 0);
        end
    end

    task automatic check_status(input string nm);
        checks++;
        if (locked !== (m_mode == 1) || holdover !== (m_mode == 2) || err !== m_err || int'(us_cnt) != m_pos) begin
            errors++;
            $display("FAIL %s: edge %0d got locked=%0b holdover=%0b err=%0b us_cnt=%0d, required %0b %0b %0b %0d",
                     nm, edge_n, locked, holdover, err, us_cnt, (m_mode == 1), (m_mode == 2), m_err, m_pos);
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: pairs every strobe with the oldest expectation
    initial begin
        exp_t e;
        int got;
        forever begin
            @(negedge clk_sys);
            while (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
                checks++; errors++;
                $display("FAIL missing_strobe: kind %0d required at edge %0d, strobe absent", exp_q[0].kind, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (fire_sync || fire_info) begin
                checks++;
                got = fire_sync ? (fire_info ? 3 : 1) : 2;
                if (exp_q.size() == 0 || exp_q[0].at != edge_n) begin
                    errors++;
                    $display("FAIL unexpected_strobe: edge %0d sync=%0b info=%0b, required none", edge_n, fire_sync, fire_info);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e.kind || int'(us_cnt) != e.us || locked !== e.lk || holdover !== e.ho || err !== e.er) begin
                        errors++;
                        $display("FAIL strobe: edge %0d got kind=%0d us=%0d lk=%0b ho=%0b err=%0b, required kind=%0d us=%0d lk=%0b ho=%0b err=%0b",
                                 edge_n, got, us_cnt, locked, holdover, err, e.kind, e.us, e.lk, e.ho, e.er);
                    end
                end
            end
            if (rst_n && (edge_n % 61 == 0)) check_status("periodic_status");
        end
    end

    task automatic wait_pos(input int target, input int budget, input string nm);
        int n = 0;
        while (m_pos != target) begin
            @(negedge clk_sys);
            n++;
            if (n > budget) begin
                checks++; errors++;
                $display("FAIL %s: timeout waiting for us position %0d", nm, target);
                return;
            end
        end
    endtask

    task automatic wait_mode(input int mode, input int budget, input string nm);
        int n = 0;
        while (m_mode != mode) begin
            @(negedge clk_sys);
            n++;
            if (n > budget) begin
                checks++; errors++;
                $display("FAIL %s: timeout waiting for mode %0d", nm, mode);
                return;
            end
        end
    endtask

    task automatic pps();
        gps_pluse = 1'b1;
        repeat (20) @(negedge clk_sys);
        gps_pluse = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        gps_pluse = 1'b0;
        repeat (5) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        check_status("reset_status");
        chk("reset_strobes", int'({fire_sync, fire_info}), 0);
        chk("reset_us_cnt", int'(us_cnt), 0);

        // First PPS locks; fire_info follows 20 us later
        repeat (100) @(negedge clk_sys);
        pps();
        chk("first_pps_locked", int'(locked), 1);
        repeat (30 * 4) @(negedge clk_sys);

        // Jittered PPS around the nominal second
        for (int i = 0; i < 2; i++) begin
            wait_pos(P - 1 + int'($urandom_range(0, 10)) - 5, 5000, "jitter_wait");
            pps();
            check_status("jitter_status");
            chk("jitter_err", int'(err), 0);
        end

        // Out-of-window PPS is ignored and flagged, next good one clears
        wait_pos(500, 5000, "oow_wait");
        pps();
        chk("oow_err", int'(err), 1);
        chk("oow_locked", int'(locked), 1);
        wait_pos(P - 1, 5000, "recover_wait");
        pps();
        chk("recover_err", int'(err), 0);

        // PPS stops: holdover, then drop to IDLE after the third miss
        wait_mode(2, 5000, "hold_wait");
        @(negedge clk_sys);
        chk("hold_flag", int'(holdover), 1);
        wait_mode(0, 9000, "idle_wait");
        @(negedge clk_sys);
        chk("idle_locked", int'(locked), 0);
        chk("idle_holdover", int'(holdover), 0);
        chk("idle_err", int'(err), 1);
        repeat (400) @(negedge clk_sys);
        check_status("idle_status");

        // Return during holdover: early in the second and mid-second
        pps();
        wait_pos(P - 1, 5000, "relock_wait");
        pps();
        wait_mode(2, 5000, "hold2_wait");
        wait_pos(4, 5000, "hold_early_wait");
        pps();
        chk("early_return_locked", int'(locked), 1);
        wait_mode(2, 5000, "hold3_wait");
        wait_pos(599, 5000, "hold_mid_wait");
        pps();
        chk("mid_return_locked", int'(locked), 1);

        // One-cycle reset mid-holdover with fire_info pending
        wait_mode(2, 5000, "hold4_wait");
        repeat (20) @(negedge clk_sys);
        rst_n = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        chk("midreset_outputs", int'({fire_sync, fire_info, locked, holdover, err}), 0);
        chk("midreset_us_cnt", int'(us_cnt), 0);
        repeat (200) @(negedge clk_sys);
        check_status("midreset_idle");

        // Randomised arrivals near the window edge
        pps();
        for (int i = 0; i < 4; i++) begin
            wait_pos(int'($urandom_range(980, 999)), 5000, "rand_wait");
            pps();
            check_status("rand_status");
        end

        repeat (200) @(negedge clk_sys);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
